// File: rtl/wallace_pkg.sv
// Shared sizing helpers for the pipelined Wallace-tree multiplier: operand/stage
// limits, product width, per-level row counts and stage-split of tree levels.
package wallace_pkg;

  localparam int WIDTH_MIN  = 8;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

  // One level of 3:2 compression: every full triple becomes a sum/carry pair.
  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int rows_at(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = rows_after(n);
    return n;
  endfunction

  function automatic int tree_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = rows_after(n);
      l++;
    end
    return l;
  endfunction

  function automatic int stage_start(input int levels, input int stages, input int s);
    return (levels * s) / stages;
  endfunction

  function automatic bit reg_after_level(input int levels, input int stages, input int l);
    for (int s = 1; s < stages; s++)
      if (stage_start(levels, stages, s) == l + 1) return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/wallace_csa_row.sv
// Row of 3:2 compressors: three addends in, sum row and left-shifted carry row out.
module wallace_csa_row #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = {(a[WIDTH-2:0] & b[WIDTH-2:0]) | (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                  (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with a single global stall.
// Optional macro WALLACE_MULT_SIGNED_EN adds in_signed and Baugh-Wooley correction.
module wallace_mult_pipe
  import wallace_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
`ifdef WALLACE_MULT_SIGNED_EN
  input  logic                   in_signed,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_result,
  output logic                   busy
);

  localparam int PW = prod_w(WIDTH);
`ifdef WALLACE_MULT_SIGNED_EN
  localparam int NPP = WIDTH + 1;
`else
  localparam int NPP = WIDTH;
`endif
  localparam int LEVELS = tree_levels(NPP);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || (WIDTH % 2) != 0 ||
      STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : bad_cfg
    $error("wallace_mult_pipe: unsupported WIDTH/STAGES");
  end

  logic                     advance;
  logic [NPP-1:0][PW-1:0]   pp_rows;
  logic [LEVELS-1:0]        cut_vld;

  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign busy     = (|cut_vld) | out_valid;

  // Signed pairs invert the cross terms with exactly one operand MSB and add 2^W + 2^(2W-1).
  always_comb begin
    pp_rows = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
`ifdef WALLACE_MULT_SIGNED_EN
        pp_rows[i][i+j] = (in_a[j] & in_b[i]) ^
                          (in_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
    pp_rows[WIDTH] = in_signed ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
`else
        pp_rows[i][i+j] = in_a[j] & in_b[i];
`endif
  end

  for (genvar l = 0; l < LEVELS; l++) begin : lvl
    localparam int N = rows_at(NPP, l);
    localparam int G = N / 3;
    localparam int M = rows_after(N);

    logic [N-1:0][PW-1:0] src;
    logic                 src_vld;
    logic [M-1:0][PW-1:0] dst;
    logic [M-1:0][PW-1:0] rows_p;
    logic                 vld_p;

    if (l == 0) begin : first
      assign src     = pp_rows;
      assign src_vld = in_valid;
    end else begin : chain
      assign src     = lvl[l-1].rows_p;
      assign src_vld = lvl[l-1].vld_p;
    end

    for (genvar g = 0; g < G; g++) begin : csa
      wallace_csa_row #(.WIDTH(PW)) u_row (
        .a    (src[3*g]),
        .b    (src[3*g+1]),
        .c    (src[3*g+2]),
        .sum  (dst[2*g]),
        .carry(dst[2*g+1])
      );
    end

    for (genvar r = 0; r < N - 3*G; r++) begin : pass
      assign dst[2*G+r] = src[3*G+r];
    end

    // Stage boundary: register the partially reduced rows and their valid bit.
    if (reg_after_level(LEVELS, STAGES, l)) begin : cut
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_p <= 1'b0;
        else if (advance) vld_p <= src_vld;
      end

      always_ff @(posedge clk) begin
        if (advance) rows_p <= dst;
      end

      assign cut_vld[l] = vld_p;
    end else begin : thru
      assign rows_p     = dst;
      assign vld_p      = src_vld;
      assign cut_vld[l] = 1'b0;
    end
  end

  // Final stage: carry-propagate add of the last two rows into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (advance) begin
      out_valid  <= lvl[LEVELS-1].vld_p;
      out_result <= lvl[LEVELS-1].rows_p[0] + lvl[LEVELS-1].rows_p[1];
    end
  end

endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16: operand width; even, 8..32.
REQ-002 Parameter STAGES, default 3: pipeline register stages; range 1..4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 in_signed  input  1  two's-complement mode for this pair; present only with WALLACE_MULT_SIGNED_EN.
REQ-010 out_valid  output  1  out_result holds a product.
REQ-011 out_ready  input  1  downstream accepts product.
REQ-012 out_result  output  2*WIDTH  full-width product.
REQ-013 busy  output  1  any pipeline stage holds a valid item.

Function
REQ-014 Product SHALL be exact full-width a*b; no truncation, no rounding.
REQ-015 Partial products SHALL be reduced by a Wallace tree of 3:2 compressors, then one final carry-propagate add.
REQ-016 Tree levels SHALL be split across STAGES register stages; each stage carries a valid bit.
REQ-017 Transfer occurs when valid and ready are both high on a rising edge, on both ports.
REQ-018 Global advance = out_ready OR NOT out_valid; in_ready SHALL equal advance.
REQ-019 When advance is low, every stage SHALL hold data and valid unchanged (full stall).
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall.
REQ-021 Throughput SHALL be one product per cycle with out_ready held high.
REQ-022 out_result and out_valid SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 in_valid=0 on an advancing cycle SHALL inject a bubble (stage valid=0); bubbles never reach out_valid.
REQ-024 Operands SHALL be ordered first-in first-out; no reordering, dropping or duplication.
REQ-025 busy SHALL be the OR of all stage valid bits.

Reset
REQ-026 rst_n low SHALL clear all stage valid bits immediately: out_valid=0, busy=0, in_ready=1, out_result=0.
REQ-027 Items in flight at reset SHALL be discarded; none emerge after release.
REQ-028 First transfer after release SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-029 Macro WALLACE_MULT_SIGNED_EN defined: in_signed exists; signed pairs use Baugh-Wooley partial-product correction, sign travels with the data per stage.
REQ-030 Macro undefined: in_signed absent; all operands unsigned; no correction logic.

Structure
REQ-031 Package wallace_pkg SHALL hold the stage-split level-count function, WIDTH/STAGES limit constants, and the product-width function.
REQ-032 Sub-module wallace_csa_row (parametric-width 3:2 compressor row) SHALL be instantiated per reduction level.

Verification
REQ-033 WIDTH=16, STAGES=3, unsigned 0xFFFF*0xFFFF -> 0xFFFE0001, out_valid exactly 3 cycles after transfer.
REQ-034 SIGNED_EN, in_signed=1: 0xFFFF*0xFFFF -> 0x00000001; 0x8000*0x7FFF -> 0xC0008000.
REQ-035 100 back-to-back random pairs, out_ready=1 -> 100 correct products on consecutive cycles, FIFO order.
REQ-036 out_ready low 5 cycles while 3 items in flight -> in_ready=0, out_result held, no loss; all 3 emerge in order afterwards.
REQ-037 rst_n pulsed low with 2 items in flight -> out_valid=0 immediately, busy=0, no stale product after release.
REQ-038 WIDTH=8, STAGES=1: 0xFF*0x02 -> 0x01FE after 1 cycle; exhaustive 65536-pair sweep matches reference product.
